fp_normalize_round: RTL and testbench

- Stage directly downstream of the mantissa add/sub stage in the single-precision FPU adder.
- Takes the 28-bit raw mantissa, result sign and pre-normalization exponent.
- Normalizes the mantissa with an iterative shifter, rounds to nearest-even, and packs an IEEE-754 single-precision result with status flags.
- Multi-cycle FSM with a simple valid/ready input handshake.

---
 rtl/fp_normalize_round_if.sv | 32 +++
 rtl/fp_normalize_round.sv | 171 +++++++++++++++++
 tb/tb_fp_normalize_round.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_round_if.sv
// Handshake and result bundle between the FPU add/sub stage, this
// normalize/round stage and whatever consumes the packed result.
interface fp_normalize_round_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28
);
  localparam int RES_W = 1 + EXP_W + (MANT_W - 5);

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mantisa_raw;
  logic              sign_result;
  logic [EXP_W-1:0]  exp_in;
  logic [RES_W-1:0]  result;
  logic              out_valid;
  logic              overflow;
  logic              underflow;
  logic              inexact;
  logic              zero;

  // upstream producer / result consumer side
  modport master (
    output in_valid, mantisa_raw, sign_result, exp_in,
    input  in_ready, result, out_valid, overflow, underflow, inexact, zero
  );

  // normalize/round stage side
  modport slave (
    input  in_valid, mantisa_raw, sign_result, exp_in,
    output in_ready, result, out_valid, overflow, underflow, inexact, zero
  );
endinterface

// File: rtl/fp_normalize_round.sv
// Single-precision adder back end: iterative normalize, round to
// nearest-even and pack with status flags.
//
// state  | meaning
// IDLE   | waiting for a word, in_ready high
// NORM   | one normalize step per cycle (right by one or left by one)
// ROUND  | nearest-even increment on m[27:3], clears g/r/s
// RENORM | rounding carried into m[27], shift right once
// PACK   | build result and flags, pulse out_valid
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_normalize_round_if.slave  bus
);

  localparam int FRAC_W = MANT_W - 5;
  localparam int SUM_W  = MANT_W - 3;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_RENORM,
    S_PACK
  } state_t;

  state_t             state_q, state_d;
  logic [MANT_W-1:0]  m_q, m_d;
  logic [EXP_W:0]     e_q, e_d;
  logic               sign_q, sign_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               inexact_q, inexact_d;
  logic               zero_q, zero_d;

  logic               lsb, g, r, s, round_up;
  logic [SUM_W-1:0]   sum;
  logic [FRAC_W-1:0]  frac;

  assign lsb      = m_q[3];
  assign g        = m_q[2];
  assign r        = m_q[1];
  assign s        = m_q[0];
  assign round_up = g & (r | s | lsb);
  assign sum      = m_q[MANT_W-1:3] + {{(SUM_W-1){1'b0}}, round_up};
  assign frac     = m_q[MANT_W-3:3];

  // Next-state, datapath and flag updates for the sequencing FSM
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    sign_d      = sign_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    zero_d      = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d         = bus.mantisa_raw;
          e_d         = {1'b0, bus.exp_in};
          sign_d      = bus.sign_result;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
          zero_d      = 1'b0;
          state_d     = S_NORM;
        end
      end

      S_NORM: begin
        if (m_q == '0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          state_d = S_PACK;
        end else if (m_q[MANT_W-1]) begin
          // carry out of the add: fold the dropped bit into sticky
          m_d     = {1'b0, m_q[MANT_W-1:2], m_q[1] | m_q[0]};
          e_d     = e_q + E_ONE;
          state_d = S_ROUND;
        end else if (m_q[MANT_W-2]) begin
          state_d = S_ROUND;
        end else if (e_q == E_ONE) begin
          // exponent floor reached: leave it as a subnormal candidate
          state_d = S_ROUND;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - E_ONE;
        end
      end

      S_ROUND: begin
        inexact_d = g | r | s;
        m_d       = {sum, 3'b000};
        state_d   = sum[SUM_W-1] ? S_RENORM : S_PACK;
      end

      S_RENORM: begin
        m_d     = m_q >> 1;
        e_d     = e_q + E_ONE;
        state_d = S_PACK;
      end

      S_PACK: begin
        if (zero_q) begin
          result_d = '0;
        end else if (e_q >= E_MAX) begin
          result_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          overflow_d = 1'b1;
        end else if (!m_q[MANT_W-2] && (frac != '0)) begin
          result_d    = {sign_q, {EXP_W{1'b0}}, frac};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_q, e_q[EXP_W-1:0], frac};
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed scoreboard bench for fp_normalize_round.
module tb_fp_normalize_round;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fp_normalize_round_if #(.EXP_W(8), .MANT_W(28)) bus ();

  fp_normalize_round #(.EXP_W(8), .MANT_W(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, inexact, zero}
    int          lat;
    int          cap;
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on every out_valid pulse
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk(32'd1, 32'd0, "unexpected_out_valid");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(bus.result, e.res, {e.tag, "_result"});
        chk({28'd0, bus.overflow, bus.underflow, bus.inexact, bus.zero},
            {28'd0, e.flg}, {e.tag, "_flags"});
        chk(cyc - e.cap, e.lat, {e.tag, "_latency"});
        chk({31'd0, bus.in_ready}, 32'd1, {e.tag, "_ready_b2b"});
      end
    end
  end

  task automatic send(input logic [27:0] m, input logic s, input logic [7:0] e,
                      input logic [31:0] res, input logic [3:0] flg, input int lat,
                      input string tag, input bit track);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({31'd0, bus.in_ready}, 32'd1, {tag, "_in_ready"});
    bus.in_valid    = 1'b1;
    bus.mantisa_raw = m;
    bus.sign_result = s;
    bus.exp_in      = e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (track) begin
      x.res = res;
      x.flg = flg;
      x.lat = lat;
      x.cap = cyc;
      x.tag = tag;
      sb.push_back(x);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size(), 32'd0, {tag, "_drain"});
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.mantisa_raw = '0;
    bus.sign_result = 1'b0;
    bus.exp_in      = '0;

    #3;
    chk(bus.result, 32'h0, "reset_result");
    chk({27'd0, bus.out_valid, bus.overflow, bus.underflow, bus.inexact, bus.zero},
        32'd0, "reset_flags");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({31'd0, bus.in_ready}, 32'd1, "reset_in_ready");

    // carry out of add: 1.0 + 1.0
    send(28'h8000000, 1'b0, 8'd127, 32'h40000000, 4'b0000, 3, "one_plus_one", 1'b1);
    // zero result forces positive sign
    send(28'h0000000, 1'b1, 8'd100, 32'h00000000, 4'b0001, 2, "zero", 1'b1);
    // three left shifts
    send(28'h0800000, 1'b0, 8'd127, 32'h3E000000, 4'b0000, 6, "lshift3", 1'b1);
    // rounding carry through RENORM
    send(28'h7FFFFFC, 1'b0, 8'd127, 32'h40000000, 4'b0010, 4, "round_carry", 1'b1);
    // exact tie, even lsb stays
    send(28'h4000004, 1'b0, 8'd127, 32'h3F800000, 4'b0010, 3, "tie_even", 1'b1);
    // tie with odd lsb rounds up
    send(28'h400000C, 1'b0, 8'd127, 32'h3F800002, 4'b0010, 3, "tie_odd", 1'b1);
    // sticky only, no round up
    send(28'h4000001, 1'b0, 8'd127, 32'h3F800000, 4'b0010, 3, "sticky", 1'b1);
    // negative normal
    send(28'h4000000, 1'b1, 8'd127, 32'hBF800000, 4'b0000, 3, "neg_one", 1'b1);
    // subnormal at exponent floor
    send(28'h2000000, 1'b0, 8'd1,   32'h00400000, 4'b0100, 3, "subnormal", 1'b1);
    // long left normalize: 23 shifts
    send(28'h0000008, 1'b0, 8'd127, 32'h34000000, 4'b0000, 26, "lshift23", 1'b1);
    // overflow to infinity
    send(28'h8000000, 1'b0, 8'd254, 32'h7F800000, 4'b1000, 3, "overflow", 1'b1);
    drain("main");

    // flags and result hold after out_valid
    repeat (5) @(negedge clk);
    chk({31'd0, bus.overflow}, 32'd1, "overflow_held");
    chk(bus.result, 32'h7F800000, "result_held");

    // flags clear on the next capture
    send(28'h4000000, 1'b0, 8'd127, 32'h3F800000, 4'b0000, 3, "after_ovf", 1'b1);
    chk({31'd0, bus.overflow}, 32'd0, "overflow_cleared_at_capture");
    drain("after_ovf");

    // reset during NORM of a left-shifting word
    send(28'h0800000, 1'b0, 8'd127, 32'h0, 4'b0000, 0, "aborted", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk(bus.result, 32'h0, "mid_reset_result");
    chk({27'd0, bus.out_valid, bus.overflow, bus.underflow, bus.inexact, bus.zero},
        32'd0, "mid_reset_flags");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({31'd0, bus.in_ready}, 32'd1, "release_in_ready");
    repeat (10) @(negedge clk);
    chk({31'd0, bus.out_valid}, 32'd0, "no_out_valid_after_abort");

    send(28'h8000000, 1'b0, 8'd127, 32'h40000000, 4'b0000, 3, "post_reset", 1'b1);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
